systolic_output_collector: RTL

Receives the skewed partial-sum stream leaving the bottom edge of the systolic array and de-skews it into a square ofmap register file for the unified buffer. It is the drain-side counterpart of `systolic_data_buffer`, which skews ifmap data into the array. Each array column delivers its rows one cycle after the column to its left. The collector aligns the columns, writes each result to its row and column position, and signals when the whole layer output has been captured.

---
 rtl/systolic_output_collector_pkg.sv | 23 ++
 rtl/valid_skew_line.sv | 42 ++++
 rtl/systolic_output_collector.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_output_collector_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types for the systolic array drain side: operation encodings, the
// output collector FSM state enum and the default partial-sum width.
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int ACC_WIDTH_DEF = 20;

    typedef enum logic {
        CONV = 1'b0,
        MUL  = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } coll_state_t;

    typedef logic signed [ACC_WIDTH_DEF-1:0] psum_t;

endpackage

// File: rtl/valid_skew_line.sv
// -----------------------------------------------------------------------------
// valid_skew_line
// Delay line for the row-valid of the systolic array drain. Column c of the
// array delivers a row c cycles after column 0, so col_v[c] is in_v delayed
// by c cycles. WIDTH-1 register stages, synchronous clear.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   clr    synchronous flush of all stages
//   in_v   valid for column 0 (undelayed)
//   col_v  per-column valid, col_v[0] = in_v
// -----------------------------------------------------------------------------
module valid_skew_line #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_v,
    output logic [WIDTH-1:0] col_v
);

    generate
        if (WIDTH > 1) begin : g_line
            logic [WIDTH-2:0] vld_pipe;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe <= (vld_pipe << 1) | (WIDTH-1)'(in_v);
                end
            end

            assign col_v = {vld_pipe, in_v};
        end else begin : g_none
            assign col_v = in_v;
        end
    endgenerate

endmodule

// File: rtl/systolic_output_collector.sv
// -----------------------------------------------------------------------------
// systolic_output_collector
// De-skews the partial-sum stream leaving the bottom edge of the systolic
// array into a HEIGHT x WIDTH ofmap register file. Column c of a row arrives
// c cycles after column 0; each column keeps its own row counter and writes
// its beat to ofmap_o[row_cnt[c]][c]. ofmap_ov pulses once the last column
// has written the last output row.
//
// Build option: define RELU_EN to clamp negative partial sums to zero on
// the write path (no added latency).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   layer_info_valid  layer dimensions below are valid
//   ifmap_height_i    ifmap rows
//   ifmap_width_i     ifmap vector length
//   weight_height_i   kernel size (CONV) / weight rows (MUL)
//   op_i              0 = CONV, 1 = MUL
//   collect_en        start request pulse
//   psum_iv           valid for column 0 of the current output row
//   psum_id           skewed array bottom-edge outputs
//   busy_o            high while collecting
//   cfg_err_o         pulse: start rejected, an output dimension is zero
//   ofmap_ov          pulse: capture complete
//   ofmap_o           captured ofmap, held until the next accepted start
// -----------------------------------------------------------------------------
module systolic_output_collector
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int HEIGHT     = 8,
    parameter int WIDTH      = 8,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int HEIGHT_W   = $clog2(HEIGHT)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  layer_info_valid,
    input  logic [HEIGHT_W:0]                     ifmap_height_i,
    input  logic [HEIGHT_W:0]                     ifmap_width_i,
    input  logic [HEIGHT_W:0]                     weight_height_i,
    input  logic                                  op_i,
    input  logic                                  collect_en,
    input  logic                                  psum_iv,
    input  logic [WIDTH-1:0][ACC_WIDTH-1:0]       psum_id,
    output logic                                  busy_o,
    output logic                                  cfg_err_o,
    output logic                                  ofmap_ov,
    output logic [HEIGHT-1:0][WIDTH-1:0][ACC_WIDTH-1:0] ofmap_o
);

    // A product of two elements must fit the accumulator.
    generate
        if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
            $error("ACC_WIDTH too narrow for DATA_WIDTH products");
        end
    endgenerate

    localparam int DW = HEIGHT_W + 1;   // dimension / row counter width

    coll_state_t                       state_q, state_d;
    logic [DW-1:0]                     out_rows_q, out_cols_q;
    logic [DW-1:0]                     rows_n, cols_n;
    logic signed [HEIGHT_W+1:0]        rows_s, cols_s;
    logic [WIDTH-1:0][DW-1:0]          row_cnt_q;
    logic [HEIGHT-1:0][WIDTH-1:0][ACC_WIDTH-1:0] ofmap_q;
    logic [WIDTH-1:0]                  col_v;
    logic [WIDTH-1:0]                  wr_en;
    logic                              busy;
    logic                              start_req, start_ok, start_bad;
    logic                              last_wr;
    logic                              cfg_err_q;

    // Non-positive dimensions count as zero. Results beyond the register
    // file are clamped so a completion can always be reached.
    function automatic logic [DW-1:0] clamp_dim(input logic signed [HEIGHT_W+1:0] v,
                                                input int lim);
        if (v <= 0)
            return '0;
        else if (int'(v) > lim)
            return DW'(lim);
        else
            return v[DW-1:0];
    endfunction

    function automatic logic [ACC_WIDTH-1:0] wr_val(input logic [ACC_WIDTH-1:0] p);
`ifdef RELU_EN
        return p[ACC_WIDTH-1] ? '0 : p;
`else
        return p;
`endif
    endfunction

    // Output dimensions from the current layer info.
    always_comb begin
        if (op_t'(op_i) == MUL) begin
            rows_s = $signed({1'b0, ifmap_height_i});
            cols_s = $signed({1'b0, weight_height_i});
        end else begin
            rows_s = $signed({1'b0, ifmap_height_i}) - $signed({1'b0, weight_height_i})
                   + $signed((HEIGHT_W+2)'(1));
            cols_s = $signed({1'b0, ifmap_width_i}) - $signed({1'b0, weight_height_i})
                   + $signed((HEIGHT_W+2)'(1));
        end
        rows_n = clamp_dim(rows_s, HEIGHT);
        cols_n = clamp_dim(cols_s, WIDTH);
    end

    assign busy      = (state_q == COLLECT);
    assign start_req = collect_en && layer_info_valid && (state_q == IDLE);
    assign start_ok  = start_req && (rows_n != '0) && (cols_n != '0);
    assign start_bad = start_req && !start_ok;

    // Beats outside COLLECT never enter the line; a start flushes it so a
    // beat in the start cycle is not captured.
    valid_skew_line #(
        .WIDTH (WIDTH)
    ) u_skew (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .in_v  (psum_iv && busy),
        .col_v (col_v)
    );

    // Per-column write enables; a column stops once it holds out_rows rows.
    always_comb begin
        wr_en   = '0;
        last_wr = 1'b0;
        for (int c = 0; c < WIDTH; c++) begin
            if (busy && col_v[c] && (c < int'(out_cols_q)) && (row_cnt_q[c] < out_rows_q)) begin
                wr_en[c] = 1'b1;
                if ((c == int'(out_cols_q) - 1) && (row_cnt_q[c] == out_rows_q - DW'(1)))
                    last_wr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = COLLECT;
            COLLECT: if (last_wr)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            cfg_err_q <= 1'b0;
        else
            cfg_err_q <= start_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_rows_q <= '0;
            out_cols_q <= '0;
            row_cnt_q  <= '0;
            ofmap_q    <= '0;
        end else if (start_ok) begin
            out_rows_q <= rows_n;
            out_cols_q <= cols_n;
            row_cnt_q  <= '0;
            ofmap_q    <= '0;
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                if (wr_en[c]) begin
                    for (int r = 0; r < HEIGHT; r++) begin
                        if (row_cnt_q[c] == DW'(r))
                            ofmap_q[r][c] <= wr_val(psum_id[c]);
                    end
                    row_cnt_q[c] <= row_cnt_q[c] + DW'(1);
                end
            end
        end
    end

    assign busy_o    = busy;
    assign cfg_err_o = cfg_err_q;
    assign ofmap_ov  = (state_q == DONE);
    assign ofmap_o   = ofmap_q;

endmodule
